ysyx_23060332_ifu: RTL and testbench
====================================

YSYX_23060332_IFU -- requirements
Module: ysyx_23060332_ifu

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port mem_addr  output  32  fetch address, meaningful while mem_req=1.
REQ-006 SHALL have port mem_ready  input  1  memory accepts request this cycle (mem_req & mem_ready = accept).
REQ-007 SHALL have port mem_rvalid  input  1  response valid, exactly one per accepted request, at least 1 cycle after accept.
REQ-008 SHALL have port mem_rdata  input  32  instruction word, valid with mem_rvalid.
REQ-009 SHALL have port inst_valid  output  1  instruction offered to decoder.
REQ-010 SHALL have port inst_ready  input  1  decoder consumes instruction (inst_valid & inst_ready = handoff).
REQ-011 SHALL have port inst_o  output  32  instruction word to decoder.
REQ-012 SHALL have port inst_addr  output  32  address of inst_o.
REQ-013 SHALL have port jump_en  input  1  single-cycle redirect from execute stage.
REQ-014 SHALL have port jump_addr  input  32  redirect target; bits [1:0] ignored and forced to 0.

Function
REQ-015 SHALL implement three states: FETCH, WAIT, HOLD; one request outstanding at most.
REQ-016 FETCH: mem_req=1, mem_addr=pc; on accept go WAIT; else stay FETCH (request is a per-cycle offer, mem_addr may change before accept).
REQ-017 WAIT: mem_req=0; on mem_rvalid with no pending flush and no jump_en that cycle, latch mem_rdata into inst_o, pc into inst_addr, go HOLD.
REQ-018 HOLD: inst_valid=1, inst_o/inst_addr stable until handoff; on handoff pc<=pc+4 (mod 2^32), go FETCH; zero-bubble not required (handoff to next request = 1 cycle).
REQ-019 jump_en in FETCH: pc<=jump_addr; if accept occurs same cycle, set flush flag and go WAIT.
REQ-020 jump_en in WAIT: pc<=jump_addr; set flush flag unless mem_rvalid same cycle, in which case discard response and go FETCH directly.
REQ-021 WAIT with flush set: on mem_rvalid discard data, clear flush, go FETCH.
REQ-022 jump_en in HOLD (with or without handoff): pc<=jump_addr, go FETCH; jump_en has priority over pc+4; a same-cycle handoff still completes.
REQ-023 A discarded response SHALL never reach inst_o or raise inst_valid.
REQ-024 inst_valid SHALL be 1 only in HOLD; mem_req only in FETCH.

Reset
REQ-025 While rst=1: state=FETCH, pc=RESET_PC, flush=0, inst_o=0, inst_addr=0, inst_valid=0, mem_req=0 (gated by rst).
REQ-026 First request after rst deassert SHALL be to RESET_PC in the first cycle; reset mid-WAIT drops the outstanding response (bench ensures memory is reset too).

Structure
REQ-027 Bus-width macros (InstBus, InstAddrBus), ZeroWord, RESET_PC value and state encodings SHALL live in the shared ysyx_23060332_define.v.
REQ-028 Next-pc selection and pc register SHALL be sub-module ysyx_23060332_pc_reg; FSM, flush flag and output buffer remain in the top.

Verification
REQ-029 Reset release, mem_ready=1, 2-cycle latency, inst_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 fetched; each inst_o matches mem_rdata.
REQ-030 inst_ready held 0 for 5 cycles in HOLD -> inst_o/inst_addr unchanged, mem_req=0, no new request.
REQ-031 jump_en=1, jump_addr=0x80000103 during WAIT, response 3 cycles later -> response discarded, next request to 0x80000100, no inst_valid for stale word.
REQ-032 jump_en with handoff in HOLD at pc=0x80000010, target 0x80000200 -> next mem_addr 0x80000200, not 0x80000014.
REQ-033 pc=0xFFFFFFFC handed off -> next mem_addr 0x00000000.
REQ-034 rst asserted asynchronously mid-WAIT -> outputs reach reset values immediately, next fetch at 0x80000000.

Source files
------------

// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared IFU definitions: bus widths, zero word, reset PC and the fetch FSM states.
package ysyx_23060332_ifu_pkg;

  localparam int                INST_BUS_W      = 32;
  localparam int                INST_ADDR_BUS_W = 32;
  localparam logic [INST_BUS_W-1:0]      ZERO_WORD   = '0;
  localparam logic [INST_ADDR_BUS_W-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [INST_ADDR_BUS_W-1:0] PC_STEP     = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } ifu_state_e;

  // Word-align a redirect target; the low two bits carry no meaning.
  function automatic logic [INST_ADDR_BUS_W-1:0] align_word(input logic [INST_ADDR_BUS_W-1:0] a);
    return {a[INST_ADDR_BUS_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_pc_reg.sv
// Program counter with next-pc selection: redirect beats sequential advance.
module ysyx_23060332_pc_reg
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [INST_ADDR_BUS_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_en,
  input  logic [INST_ADDR_BUS_W-1:0] jump_addr,
  input  logic                       adv,
  output logic [INST_ADDR_BUS_W-1:0] pc
);

  logic [INST_ADDR_BUS_W-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc;
    if (jump_en)  pc_nxt = align_word(jump_addr);
    else if (adv) pc_nxt = pc + PC_STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_nxt;
  end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding memory request, a one-entry output
// buffer toward the decoder, and redirect handling that discards stale responses.
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [INST_ADDR_BUS_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [INST_ADDR_BUS_W-1:0] mem_addr,
  input  logic                       mem_ready,
  input  logic                       mem_rvalid,
  input  logic [INST_BUS_W-1:0]      mem_rdata,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INST_BUS_W-1:0]      inst_o,
  output logic [INST_ADDR_BUS_W-1:0] inst_addr,
  input  logic                       jump_en,
  input  logic [INST_ADDR_BUS_W-1:0] jump_addr
);

  ifu_state_e                 state_q, state_d;
  logic                       flush_q, flush_d;
  logic                       latch;
  logic                       adv;
  logic                       accept;
  logic [INST_ADDR_BUS_W-1:0] pc;

  ysyx_23060332_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .adv       (adv),
    .pc        (pc)
  );

  assign mem_req    = (state_q == ST_FETCH) & ~rst;
  assign mem_addr   = pc;
  assign accept     = mem_req & mem_ready;
  assign inst_valid = (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    latch   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // A redirect in the accept cycle leaves the just-issued fetch stale.
        if (accept) begin
          state_d = ST_WAIT;
          flush_d = jump_en;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          flush_d = 1'b0;
          if (flush_q || jump_en) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
            latch   = 1'b1;
          end
        end else if (jump_en) begin
          flush_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (jump_en) begin
          state_d = ST_FETCH;
        end else if (inst_ready) begin
          state_d = ST_FETCH;
          adv     = 1'b1;
        end
      end
      default: begin
        state_d = ST_FETCH;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // pc still names the outstanding fetch here: any redirect blocks the latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o    <= ZERO_WORD;
      inst_addr <= '0;
    end else if (latch) begin
      inst_o    <= mem_rdata;
      inst_addr <= pc;
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Randomized plus directed bench for the IFU against a transaction-level fetch model.
module tb_ysyx_23060332_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        jump_en;
  logic [31:0] jump_addr;

  ysyx_23060332_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_o     (inst_o),
    .inst_addr  (inst_addr),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level view: is a fetch in flight, will its answer be thrown
  // away, and which instruction is the decoder being offered.
  bit          m_busy, m_stale, m_have, m_acc_now;
  logic [31:0] m_pc, m_inst, m_iaddr;
  logic [31:0] acc_q[$];
  logic [31:0] hand_q[$];

  // Instruction memory: one pending response with a countdown.
  bit          mpend;
  logic [31:0] maddr;
  int          mcnt;
  int          lat_fix;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic model_reset();
    m_busy = 0; m_stale = 0; m_have = 0; m_acc_now = 0;
    m_pc = 32'h8000_0000; m_inst = 0; m_iaddr = 0;
    mpend = 0; mcnt = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic compare_outputs();
    bit exp_req;
    exp_req = !m_have && !m_busy;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) chk("mem_addr", mem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_have));
    if (m_have) begin
      chk("inst_o", inst_o, m_inst);
      chk("inst_addr", inst_addr, m_iaddr);
      chk("inst_o vs memory", inst_o, word(inst_addr));
    end
  endtask

  task automatic mem_drive();
    mem_rvalid = 0;
    mem_rdata  = $urandom;
    if (mpend) begin
      mcnt--;
      if (mcnt <= 0) begin
        mem_rvalid = 1;
        mem_rdata  = word(maddr);
      end
    end
  endtask

  task automatic model_update();
    bit          acc;
    logic [31:0] ja;
    ja  = jump_addr & 32'hFFFF_FFFC;
    acc = !m_have && !m_busy && mem_ready;
    m_acc_now = acc;
    if (mem_rvalid) mpend = 0;
    if (acc) begin
      acc_q.push_back(mem_addr);
      mpend = 1;
      maddr = mem_addr;
      mcnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
    end
    if (m_have) begin
      if (inst_ready) hand_q.push_back(m_iaddr);
      if (jump_en)         begin m_pc = ja;            m_have = 0; end
      else if (inst_ready) begin m_pc = m_pc + 32'd4;  m_have = 0; end
    end else if (!m_busy) begin
      if (acc) begin m_busy = 1; m_stale = jump_en; end
      if (jump_en) m_pc = ja;
    end else begin
      if (mem_rvalid) begin
        m_busy = 0;
        if (!m_stale && !jump_en) begin
          m_have = 1; m_inst = mem_rdata; m_iaddr = m_pc;
        end
        m_stale = 0;
      end else if (jump_en) begin
        m_stale = 1;
      end
      if (jump_en) m_pc = ja;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_outputs();
    mem_drive();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_until_accept(input string nm, input logic [31:0] exp);
    int n0;
    int k;
    n0 = acc_q.size();
    k  = 0;
    while (acc_q.size() == n0 && k < 60) begin step(); k++; end
    if (acc_q.size() == n0) fail_now(nm);
    else chk(nm, acc_q[n0], exp);
  endtask

  task automatic wait_have(input string nm, input logic [31:0] a);
    int k;
    k = 0;
    while (!(m_have && m_iaddr == a) && k < 80) begin step(); k++; end
    if (!(m_have && m_iaddr == a)) fail_now(nm);
  endtask

  task automatic wait_accept(input string nm);
    int k;
    k = 0;
    do begin step(); k++; end while (!m_acc_now && k < 60);
    if (!m_acc_now) fail_now(nm);
  endtask

  initial begin
    int n0, nh;
    rst = 1; mem_ready = 0; inst_ready = 0; jump_en = 0; jump_addr = 0; lat_fix = 2;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset inst_valid", 32'(inst_valid), 32'd0);
    chk("reset inst_o", inst_o, 32'd0);
    chk("reset inst_addr", inst_addr, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Straight-line fetch: always ready, latency 2, decoder always ready.
    mem_ready = 1; inst_ready = 1;
    repeat (18) step();
    if (acc_q.size() < 3) fail_now("seq fetch count");
    else begin
      chk("seq fetch 0", acc_q[0], 32'h8000_0000);
      chk("seq fetch 1", acc_q[1], 32'h8000_0004);
      chk("seq fetch 2", acc_q[2], 32'h8000_0008);
    end
    if (hand_q.size() < 1) fail_now("seq handoff");
    else chk("seq handoff 0", hand_q[0], 32'h8000_0000);

    // Redirect during WAIT; the response lands three cycles after the jump.
    lat_fix = 4;
    wait_accept("jump-in-wait accept");
    nh = hand_q.size();
    jump_en = 1; jump_addr = 32'h8000_0103;
    step();
    jump_en = 0;
    run_until_accept("jump-in-wait target", 32'h8000_0100);
    chk("stale word not handed off", 32'(hand_q.size()), 32'(nh));

    // Decoder stall in HOLD, then redirect together with a handoff.
    lat_fix = 2; inst_ready = 0;
    jump_en = 1; jump_addr = 32'h8000_0010;
    step();
    jump_en = 0;
    wait_have("reach hold at 0x80000010", 32'h8000_0010);
    n0 = acc_q.size();
    repeat (5) step();
    chk("stall no new request", 32'(acc_q.size()), 32'(n0));
    chk("stall inst_addr", inst_addr, 32'h8000_0010);
    chk("stall inst_o", inst_o, word(32'h8000_0010));
    nh = hand_q.size();
    jump_en = 1; jump_addr = 32'h8000_0200; inst_ready = 1;
    step();
    jump_en = 0;
    chk("jump+handoff completes", 32'(hand_q.size()), 32'(nh + 1));
    run_until_accept("jump in hold target", 32'h8000_0200);

    // Address wrap at the top of the space.
    inst_ready = 0;
    jump_en = 1; jump_addr = 32'hFFFF_FFFE;
    step();
    jump_en = 0;
    wait_have("reach hold at 0xfffffffc", 32'hFFFF_FFFC);
    inst_ready = 1;
    step();
    run_until_accept("pc wrap", 32'h0000_0000);

    // Random traffic.
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      jump_en    = ($urandom_range(0, 11) == 0);
      jump_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      mem_ready  = $urandom_range(0, 1);
      inst_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    // Asynchronous reset while a response is outstanding.
    jump_en = 0; mem_ready = 1; inst_ready = 1; lat_fix = 3;
    repeat (6) step();
    wait_accept("reset-in-wait accept");
    step();
    rst = 1;
    #1;
    chk("async rst mem_req", 32'(mem_req), 32'd0);
    chk("async rst inst_valid", 32'(inst_valid), 32'd0);
    chk("async rst inst_o", inst_o, 32'd0);
    chk("async rst inst_addr", inst_addr, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    n0 = acc_q.size();
    step();
    if (acc_q.size() == n0) fail_now("first fetch after reset");
    else chk("first fetch after reset", acc_q[n0], 32'h8000_0000);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
